// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, alu_op bit
// positions, divider state encoding and a small arithmetic helper.
package exe_stage_pkg;

  localparam int ID_EXE_W  = 187;
  localparam int EXE_MEM_W = 71;
  localparam int EXE_WR_W  = 39;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLT   = 2;
  localparam int OP_SLTU  = 3;
  localparam int OP_AND   = 4;
  localparam int OP_NOR   = 5;
  localparam int OP_OR    = 6;
  localparam int OP_XOR   = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SRL   = 9;
  localparam int OP_SRA   = 10;
  localparam int OP_LUI   = 11;
  localparam int OP_MUL   = 12;
  localparam int OP_MULH  = 13;
  localparam int OP_MULHU = 14;
  localparam int OP_DIVW  = 15;
  localparam int OP_DIVWU = 16;
  localparam int OP_MODW  = 17;
  localparam int OP_MODWU = 18;

  // Last iteration index of the 32-step restoring divider
  localparam logic [4:0] DIV_LAST = 5'd31;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Two's complement negation of a 32-bit word
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Handshake and bus signals around the execute stage. The slave modport is
// the EXE view; the master modport is the ID/MEM/data-SRAM side.
interface exe_stage_if;
  import exe_stage_pkg::*;

  logic                 id_exe_valid;
  logic                 exe_allowin;
  logic [ID_EXE_W-1:0]  id_exe_bus;
  logic                 mem_allowin;
  logic                 exe_mem_valid;
  logic [EXE_MEM_W-1:0] exe_mem_bus;
  logic [EXE_WR_W-1:0]  exe_wr_bus;
  logic                 data_sram_en;
  logic [3:0]           data_sram_we;
  logic [31:0]          data_sram_addr;
  logic [31:0]          data_sram_wdata;

  modport slave (
    input  id_exe_valid, id_exe_bus, mem_allowin,
    output exe_allowin, exe_mem_valid, exe_mem_bus, exe_wr_bus,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport master (
    output id_exe_valid, id_exe_bus, mem_allowin,
    input  exe_allowin, exe_mem_valid, exe_mem_bus, exe_wr_bus,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

endinterface

// File: rtl/exe_div.sv
// Iterative 32-step restoring divider. Signed operands are reduced to
// magnitudes on start and the signs are reapplied to the final result.
module exe_div
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        ack,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_t  state_q, state_d;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic [4:0]  cnt_q;
  logic        q_neg_q, r_neg_q, dz_q;

  logic [32:0] part;
  logic        ge;
  logic [31:0] rem_d, quo_d;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  assign part  = {rem_q, quo_q[31]};
  assign ge    = part >= {1'b0, dvs_q};
  assign rem_d = ge ? (part[31:0] - dvs_q) : part[31:0];
  assign quo_d = {quo_q[30:0], ge};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= DIV_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start)             state_d = DIV_BUSY;
      DIV_BUSY: if (cnt_q == DIV_LAST) state_d = DIV_DONE;
      DIV_DONE: if (ack)               state_d = DIV_IDLE;
      default:                         state_d = DIV_IDLE;
    endcase
  end

  // Operand capture on start, then one iteration per BUSY cycle
  always_ff @(posedge clk) begin
    if (state_q == DIV_IDLE && start) begin
      rem_q   <= 32'd0;
      quo_q   <= (signed_op && dividend[31]) ? neg32(dividend) : dividend;
      dvs_q   <= (signed_op && divisor[31])  ? neg32(divisor)  : divisor;
      q_neg_q <= signed_op & (dividend[31] ^ divisor[31]);
      r_neg_q <= signed_op & dividend[31];
      dz_q    <= (divisor == 32'd0);
      cnt_q   <= 5'd0;
    end else if (state_q == DIV_BUSY) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 5'd1;
    end
  end

  // Divide-by-zero forces an all-ones quotient; the remainder path already
  // reproduces the dividend because every trial subtraction of 0 succeeds.
  assign done      = (state_q == DIV_DONE);
  assign quotient  = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? neg32(quo_q) : quo_q);
  assign remainder = r_neg_q ? neg32(rem_q) : rem_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the ID bundle, computes ALU/multiply/divide results,
// issues the data-SRAM request and reports bypass/block info back to ID.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  exe_stage_if.slave  bus
);

  logic                exe_valid_q;
  logic [ID_EXE_W-1:0] bundle_q;

  logic        gr_we, mem_we, res_from_mem;
  logic [18:0] alu_op;
  logic [31:0] src1, src2, rkd_value, inst, pc;
  logic [4:0]  dest, shamt;
  logic        unused_inst;

  logic        ready_go, is_div, div_done, div_ack;
  logic [31:0] div_quo, div_rem;
  logic [31:0] add_res, mulh_s, result;
  logic [63:0] umul;
  logic        en_bypass, en_block;

  // Pipeline valid: refilled whenever EXE can accept
  always_ff @(posedge clk) begin
    if (reset)                 exe_valid_q <= 1'b0;
    else if (bus.exe_allowin)  exe_valid_q <= bus.id_exe_valid;
  end

  // Bundle capture on an accepted transfer
  always_ff @(posedge clk) begin
    if (bus.id_exe_valid && bus.exe_allowin) bundle_q <= bus.id_exe_bus;
  end

  assign {gr_we, mem_we, res_from_mem, alu_op, src1, src2,
          dest, rkd_value, inst, pc} = bundle_q;
  assign unused_inst = ^inst;
  assign shamt       = src2[4:0];

  // Single multiplier; the signed high word is corrected from the unsigned one
  assign add_res = src1 + src2;
  assign umul    = {32'd0, src1} * {32'd0, src2};
  assign mulh_s  = umul[63:32] - (src1[31] ? src2 : 32'd0)
                               - (src2[31] ? src1 : 32'd0);

  assign is_div   = |alu_op[OP_MODWU:OP_DIVW];
  assign ready_go = ~is_div | div_done;
  assign div_ack  = bus.exe_mem_valid & bus.mem_allowin;

  exe_div u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (exe_valid_q & is_div),
    .signed_op (alu_op[OP_DIVW] | alu_op[OP_MODW]),
    .dividend  (src1),
    .divisor   (src2),
    .ack       (div_ack),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Result select from the one-hot alu_op
  always_comb begin
    result = 32'd0;
    if (alu_op[OP_ADD])   result = add_res;
    if (alu_op[OP_SUB])   result = src1 - src2;
    if (alu_op[OP_SLT])   result = {31'd0, $signed(src1) < $signed(src2)};
    if (alu_op[OP_SLTU])  result = {31'd0, src1 < src2};
    if (alu_op[OP_AND])   result = src1 & src2;
    if (alu_op[OP_NOR])   result = ~(src1 | src2);
    if (alu_op[OP_OR])    result = src1 | src2;
    if (alu_op[OP_XOR])   result = src1 ^ src2;
    if (alu_op[OP_SLL])   result = src1 << shamt;
    if (alu_op[OP_SRL])   result = src1 >> shamt;
    if (alu_op[OP_SRA])   result = $unsigned($signed(src1) >>> shamt);
    if (alu_op[OP_LUI])   result = src2;
    if (alu_op[OP_MUL])   result = umul[31:0];
    if (alu_op[OP_MULH])  result = mulh_s;
    if (alu_op[OP_MULHU]) result = umul[63:32];
    if (alu_op[OP_DIVW] | alu_op[OP_DIVWU]) result = div_quo;
    if (alu_op[OP_MODW] | alu_op[OP_MODWU]) result = div_rem;
  end

  assign en_bypass = exe_valid_q & gr_we & ~res_from_mem & ready_go & (dest != 5'd0);
  assign en_block  = exe_valid_q & gr_we & (dest != 5'd0) & (res_from_mem | ~ready_go);

  assign bus.exe_allowin   = ~exe_valid_q | (ready_go & bus.mem_allowin);
  assign bus.exe_mem_valid = exe_valid_q & ready_go;
  assign bus.exe_mem_bus   = {res_from_mem, gr_we, dest, result, pc};
  assign bus.exe_wr_bus    = {en_bypass, en_block, dest, result};

  // SRAM request only on the handoff cycle so backpressure cannot repeat it
  assign bus.data_sram_en    = exe_valid_q & (res_from_mem | mem_we) & ready_go & bus.mem_allowin;
  assign bus.data_sram_we    = {4{mem_we & bus.data_sram_en}};
  assign bus.data_sram_addr  = add_res;
  assign bus.data_sram_wdata = rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed bundles push their expected
// exe_mem_bus word; a negedge monitor pops and compares on every handoff.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exe_stage_if bus_if();

  exe_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks   = 0;
  int failures = 0;
  logic [EXE_MEM_W-1:0] sb_q[$];
  logic [EXE_MEM_W-1:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [ID_EXE_W-1:0] mk(input logic gw, input logic mw, input logic rfm,
      input int op, input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] d,
      input logic [31:0] rkd, input logic [31:0] pc);
    logic [18:0] o;
    o = 19'd1 << op;
    return {gw, mw, rfm, o, s1, s2, d, rkd, 32'h0, pc};
  endfunction

  task automatic push(input logic gw, input logic rfm, input logic [4:0] d,
                      input logic [31:0] res, input logic [31:0] pc);
    sb_q.push_back({rfm, gw, d, res, pc});
  endtask

  // Hold the bundle until EXE accepts it; returns 1ns after the accepting edge
  task automatic issue(input logic [ID_EXE_W-1:0] b);
    int n;
    bus_if.id_exe_bus   = b;
    bus_if.id_exe_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.exe_allowin && n < 200);
    if (!bus_if.exe_allowin) chk("issue_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus_if.id_exe_valid = 1'b0;
  endtask

  // Divide: count en_block cycles until the result is presented
  task automatic run_div(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name, input logic hold);
    int blk;
    int n;
    push(1'b1, 1'b0, 5'd9, exp, 32'h1c00_0200);
    if (hold) bus_if.mem_allowin = 1'b0;
    issue(mk(1'b1, 1'b0, 1'b0, op, a, b, 5'd9, 32'h0, 32'h1c00_0200));
    blk = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus_if.exe_mem_valid || n >= 100) break;
      if (bus_if.exe_wr_bus[37]) blk++;
      n++;
    end
    chk({name, "_block_cycles"}, blk, 33);
    chk({name, "_bypass_done"}, bus_if.exe_wr_bus[38], 1);
    chk({name, "_block_done"}, bus_if.exe_wr_bus[37], 0);
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        chk({name, "_hold_valid"}, bus_if.exe_mem_valid, 1);
        chk({name, "_hold_bypass"}, bus_if.exe_wr_bus[38], 1);
        chk({name, "_hold_wdata"}, bus_if.exe_wr_bus[31:0], exp);
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus_if.mem_allowin = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b0 && bus_if.exe_mem_valid && bus_if.mem_allowin) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got %h expected no handoff", bus_if.exe_mem_bus);
      end else begin
        mon_exp = sb_q.pop_front();
        if (bus_if.exe_mem_bus !== mon_exp) begin
          failures++;
          $display("FAIL sb_exe_mem_bus: got %h expected %h", bus_if.exe_mem_bus, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int          a_op [14] = '{OP_SUB, OP_SLT, OP_SLTU, OP_AND, OP_NOR, OP_OR, OP_XOR,
                             OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_MUL, OP_MULH, OP_MULHU};
  logic [31:0] a_s1 [14] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h0,
                             32'hF0F0F0F0, 32'hFF00FF00, 32'h1, 32'h80000000, 32'h80000000,
                             32'h0, 32'h00010000, 32'hFFFFFFFE, 32'hFFFFFFFF};
  logic [31:0] a_s2 [14] = '{32'd7, 32'h1, 32'h1, 32'hFF00FF00, 32'h0000FFFF,
                             32'h0F0F0000, 32'h0FF00FF0, 32'h3F, 32'h4, 32'h4,
                             32'hABCDE000, 32'h00010001, 32'h3, 32'hFFFFFFFF};
  logic [31:0] a_ex [14] = '{32'hFFFFFFFE, 32'h1, 32'h0, 32'hF000F000, 32'hFFFF0000,
                             32'hFFFFF0F0, 32'hF0F0F0F0, 32'h80000000, 32'h08000000,
                             32'hF8000000, 32'hABCDE000, 32'h00010000, 32'hFFFFFFFF,
                             32'hFFFFFFFE};

  initial begin
    reset               = 1'b1;
    bus_if.id_exe_valid = 1'b0;
    bus_if.id_exe_bus   = '0;
    bus_if.mem_allowin  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_allowin", bus_if.exe_allowin, 1);
    chk("rst_mem_valid", bus_if.exe_mem_valid, 0);
    chk("rst_sram_en", bus_if.data_sram_en, 0);
    chk("rst_sram_we", bus_if.data_sram_we, 0);
    chk("rst_bypass", bus_if.exe_wr_bus[38], 0);
    chk("rst_block", bus_if.exe_wr_bus[37], 0);
    @(posedge clk);
    #1;

    // add.w 5+7 -> 12
    push(1'b1, 1'b0, 5'd3, 32'd12, 32'h1c00_0000);
    issue(mk(1'b1, 1'b0, 1'b0, OP_ADD, 32'd5, 32'd7, 5'd3, 32'h0, 32'h1c00_0000));
    @(negedge clk);
    chk("add_bypass", bus_if.exe_wr_bus[38], 1);
    chk("add_mem_valid", bus_if.exe_mem_valid, 1);
    chk("add_wr_dest", bus_if.exe_wr_bus[36:32], 3);
    chk("add_wr_data", bus_if.exe_wr_bus[31:0], 12);
    @(posedge clk);
    #1;

    // ld.w at 0x1000+4
    push(1'b1, 1'b1, 5'd4, 32'h1004, 32'h1c00_0004);
    issue(mk(1'b1, 1'b0, 1'b1, OP_ADD, 32'h1000, 32'd4, 5'd4, 32'h0, 32'h1c00_0004));
    @(negedge clk);
    chk("ld_block", bus_if.exe_wr_bus[37], 1);
    chk("ld_bypass", bus_if.exe_wr_bus[38], 0);
    chk("ld_sram_en", bus_if.data_sram_en, 1);
    chk("ld_sram_addr", bus_if.data_sram_addr, 32'h1004);
    chk("ld_sram_we", bus_if.data_sram_we, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ld_sram_en_once", bus_if.data_sram_en, 0);
    @(posedge clk);
    #1;

    // ALU and multiply vectors, issued back to back
    for (int i = 0; i < 14; i++) begin
      push(1'b1, 1'b0, 5'd8, a_ex[i], 32'h1c00_0100 + 32'(4 * i));
      issue(mk(1'b1, 1'b0, 1'b0, a_op[i], a_s1[i], a_s2[i], 5'd8, 32'h0,
               32'h1c00_0100 + 32'(4 * i)));
    end

    // Divider cases
    run_div(OP_DIVW,  32'd100,      32'd7,        32'd14,       "divw_100_7",   1'b0);
    run_div(OP_MODW,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "modw_m7_2",    1'b0);
    run_div(OP_DIVW,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, "divw_ovf",     1'b1);
    run_div(OP_DIVWU, 32'h00001234, 32'h0,        32'hFFFFFFFF, "divwu_zero",   1'b0);

    // st.w with 3 cycles of backpressure
    bus_if.mem_allowin = 1'b0;
    push(1'b0, 1'b0, 5'd0, 32'h20, 32'h1c00_0300);
    issue(mk(1'b0, 1'b1, 1'b0, OP_ADD, 32'h20, 32'h0, 5'd0, 32'hDEADBEEF, 32'h1c00_0300));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st_sram_en_stalled", bus_if.data_sram_en, 0);
      @(posedge clk);
      #1;
    end
    bus_if.mem_allowin = 1'b1;
    @(negedge clk);
    chk("st_sram_en", bus_if.data_sram_en, 1);
    chk("st_sram_we", bus_if.data_sram_we, 4'hF);
    chk("st_sram_addr", bus_if.data_sram_addr, 32'h20);
    chk("st_sram_wdata", bus_if.data_sram_wdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("st_sram_en_once", bus_if.data_sram_en, 0);
    @(posedge clk);
    #1;

    // Reset while the divider is iterating
    issue(mk(1'b1, 1'b0, 1'b0, OP_DIVW, 32'd1000, 32'd3, 5'd9, 32'h0, 32'h1c00_0400));
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstdiv_mem_valid", bus_if.exe_mem_valid, 0);
    chk("rstdiv_block", bus_if.exe_wr_bus[37], 0);
    chk("rstdiv_allowin", bus_if.exe_allowin, 1);
    chk("rstdiv_sram_en", bus_if.data_sram_en, 0);
    @(posedge clk);
    #1;
    push(1'b1, 1'b0, 5'd5, 32'h0, 32'h1c00_0404);
    issue(mk(1'b1, 1'b0, 1'b0, OP_ADD, 32'hFFFFFFFF, 32'h1, 5'd5, 32'h0, 32'h1c00_0404));
    @(negedge clk);
    chk("rstdiv_add_1cycle", bus_if.exe_mem_valid, 1);
    @(posedge clk);
    #1;

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
